// File: rtl/bm_stmt_lut_arbiter_pkg.sv
// Shared widths, FSM state encoding and lookup-mode constants for the LUT arbiter.
package bm_stmt_lut_arbiter_pkg;

  // Default operand/result width of the shared lookup datapath.
  localparam int unsigned LUT_BITS = 4;

  // Default width of the completed-operation counter.
  localparam int unsigned OP_CNT_BITS = 8;

  // Sequencer states, 2-bit binary in pipeline order.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Lookup modes, selected by b_in at operand capture.
  localparam logic MODE_CPL = 1'b0;
  localparam logic MODE_INC = 1'b1;

endpackage : bm_stmt_lut_arbiter_pkg

// File: rtl/bm_lut_unit.sv
// Registered 4-bit lookup table: bitwise complement or wrapping increment.
module bm_lut_unit
  import bm_stmt_lut_arbiter_pkg::*;
#(
  parameter int unsigned BITS = LUT_BITS
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [BITS-1:0] op,
  input  logic            mode,
  input  logic            en,
  output logic [BITS-1:0] lut
);

  logic [BITS-1:0] lut_nxt;

  // Table lookup; the increment wraps naturally at 2^BITS.
  always_comb begin
    lut_nxt = ~op;
    case (mode)
      MODE_CPL: lut_nxt = ~op;
      MODE_INC: lut_nxt = op + BITS'(1);
    endcase
  end

  // Result register, loaded only while the sequencer is in EXEC.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lut <= '0;
    end else if (en) begin
      lut <= lut_nxt;
    end
  end

endmodule : bm_lut_unit

// File: rtl/bm_stmt_lut_arbiter.sv
// Two-requester round-robin arbiter sequencing a shared registered lookup unit.
module bm_stmt_lut_arbiter
  import bm_stmt_lut_arbiter_pkg::*;
#(
  parameter int unsigned BITS     = LUT_BITS,
  parameter int unsigned CNT_BITS = OP_CNT_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req0,
  input  logic [BITS-1:0]     a0,
  input  logic                req1,
  input  logic [BITS-1:0]     a1,
  input  logic                b_in,
  output logic                gnt0,
  output logic                gnt1,
  output logic                busy,
  output logic                done,
  output logic [BITS-1:0]     res,
  output logic                res_zero,
  output logic                res_id,
  output logic [CNT_BITS-1:0] op_cnt
);

  state_e          state;
  state_e          next_state;
  logic            sel;
  logic            last;
  logic            win;
  logic [BITS-1:0] op_r;
  logic            mode_r;
  logic            lut_en;

  // Round-robin pick: a lone request wins, a tie goes to the index not served last.
  always_comb begin
    win = req1;
    if (req0 && req1) begin
      win = ~last;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and state-decoded outputs; grants come from the sel register.
  always_comb begin
    next_state = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    lut_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        gnt0       = ~sel;
        gnt1       = sel;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        lut_en     = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Winner latch, operand capture, result owner and completion counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sel    <= 1'b0;
      last   <= 1'b1;
      op_r   <= '0;
      mode_r <= MODE_CPL;
      res_id <= 1'b0;
      op_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            sel <= win;
          end
        end
        ST_LOAD: begin
          last   <= sel;
          op_r   <= sel ? a1 : a0;
          mode_r <= b_in;
        end
        ST_EXEC: begin
          // Owner and count move together with the result on entry to DONE.
          res_id <= sel;
          op_cnt <= op_cnt + CNT_BITS'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Shared lookup datapath; its register is the visible result.
  bm_lut_unit #(
    .BITS (BITS)
  ) u_lut (
    .clock   (clock),
    .reset_n (reset_n),
    .op      (op_r),
    .mode    (mode_r),
    .en      (lut_en),
    .lut     (res)
  );

  // Zero flag decoded from the result register.
  assign res_zero = (res == '0);

endmodule : bm_stmt_lut_arbiter

// File: tb/tb_bm_stmt_lut_arbiter.sv
// Randomized self-checking bench for bm_stmt_lut_arbiter against a transaction-level model.
module tb_bm_stmt_lut_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0 = 1'b0;
  logic [3:0] a0 = '0;
  logic       req1 = 1'b0;
  logic [3:0] a1 = '0;
  logic       b_in = 1'b0;
  logic       gnt0, gnt1, busy, done, res_zero, res_id;
  logic [3:0] res;
  logic [7:0] op_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: who was served last, completed count, last visible result.
  int model_last = 1;
  int model_cnt  = 0;
  int model_res  = 0;

  bm_stmt_lut_arbiter #(.BITS(4), .CNT_BITS(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req0     (req0),
    .a0       (a0),
    .req1     (req1),
    .a1       (a1),
    .b_in     (b_in),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .res_zero (res_zero),
    .res_id   (res_id),
    .op_cnt   (op_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lut_ref(input int v, input int m);
    return m != 0 ? (v + 1) % 16 : 15 - v;
  endfunction

  // Synchronous reset for two cycles; model returns to its power-on view.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clock);
    reset_n    = 1'b1;
    model_last = 1;
    model_cnt  = 0;
    model_res  = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt0"}, 32'(gnt0), 0);
    check({tag, "_gnt1"}, 32'(gnt1), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_res"}, 32'(res), 32'(model_res));
    check({tag, "_op_cnt"}, 32'(op_cnt), 32'(model_cnt));
  endtask

  // One full transaction, started at a negedge with the DUT idle.
  task automatic do_op(input logic r0, input logic r1, input logic [3:0] v0,
                       input logic [3:0] v1, input logic m);
    int exp_w;
    int n;
    exp_w = (r0 && r1) ? 1 - model_last : (r1 ? 1 : 0);
    req0 = r0;
    req1 = r1;
    a0   = v0;
    a1   = v1;
    b_in = m;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(gnt0 || gnt1) && n < 8);
    check("gnt_latency", 32'(n), 1);
    check("gnt0", 32'(gnt0), 32'(exp_w == 0));
    check("gnt1", 32'(gnt1), 32'(exp_w == 1));
    check("busy_load", 32'(busy), 1);
    model_last = exp_w;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    check("done_exec", 32'(done), 0);
    check("res_stable", 32'(res), 32'(model_res));
    @(negedge clock);
    model_cnt = (model_cnt + 1) % 256;
    model_res = lut_ref(exp_w == 1 ? int'(v1) : int'(v0), int'(m));
    check("done", 32'(done), 1);
    check("res", 32'(res), 32'(model_res));
    check("res_zero", 32'(res_zero), 32'(model_res == 0));
    check("res_id", 32'(res_id), 32'(exp_w));
    check("op_cnt", 32'(op_cnt), 32'(model_cnt));
    @(negedge clock);
    check("done_after", 32'(done), 0);
    check("busy_after", 32'(busy), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc[4];
    int done_val[4];
    int done_own[4];
    int nd;
    logic r0, r1;

    // Reset values.
    do_reset();
    check_idle_outputs("reset");
    check("reset_res_zero", 32'(res_zero), 1);
    check("reset_res_id", 32'(res_id), 0);

    // Single complement request.
    do_op(1'b1, 1'b0, 4'b0011, 4'd0, 1'b0);

    // Continuous tie from a fresh reset: grants alternate starting with 0.
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    a0   = 4'd5;
    a1   = 4'd9;
    b_in = 1'b0;
    nd   = 0;
    for (int cyc = 0; cyc < 40 && nd < 4; cyc++) begin
      @(negedge clock);
      if (done) begin
        done_cyc[nd] = cyc;
        done_val[nd] = int'(res);
        done_own[nd] = int'(res_id);
        nd++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("tie_done_count", 32'(nd), 4);
    for (int i = 0; i < nd; i++) begin
      check("tie_res", 32'(done_val[i]), (i % 2 == 0) ? 10 : 6);
      check("tie_id", 32'(done_own[i]), 32'(i % 2));
      if (i > 0) check("tie_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 4);
    end
    @(negedge clock);
    model_last = (nd % 2 == 0) ? 1 : 0;
    model_cnt  = nd;
    model_res  = (nd == 0) ? 0 : done_val[nd-1];
    check_idle_outputs("tie_end");

    // Increment wrap to zero.
    do_op(1'b0, 1'b1, 4'd0, 4'b1111, 1'b1);

    // Reset while EXEC: no done, counter and result back to reset values.
    req0 = 1'b1;
    a0   = 4'd7;
    b_in = 1'b0;
    @(negedge clock);
    req0 = 1'b0;
    @(negedge clock);
    check("midrst_in_exec", 32'(busy), 1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n    = 1'b1;
    model_last = 1;
    model_cnt  = 0;
    model_res  = 0;
    check_idle_outputs("midrst");
    do_op(1'b1, 1'b1, 4'd2, 4'd4, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      do_op(r0, r1, 4'($urandom), 4'($urandom), 1'($urandom));
    end

    // 256 back-to-back operations wrap the counter to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_op(1'($urandom), 1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
    end
    check("cnt_wrap", 32'(op_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bm_stmt_lut_arbiter

// File: doc/bm_stmt_lut_arbiter.md
# bm_stmt_lut_arbiter

Round-robin arbiter and sequencer that shares one registered 4-bit lookup datapath between two requesters. The datapath is a case-style table with two modes: complement (`15 - a`) or increment with wrap. The block grants one requester at a time, captures its operand, runs the lookup, returns the result with a done pulse, and counts completed operations. It sits in the micro-benchmark set as the control counterpart to the flat case/if statement benchmarks.

## Interface
- `BITS`, default 4: operand and result width.
- `CNT_BITS`, default 8: width of the completed-operation counter.
- `clock`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `req0`, input, 1: request from requester 0; held high until `gnt0`.
- `a0`, input, BITS: operand of requester 0; must be valid while `req0` is high.
- `req1`, input, 1: request from requester 1; held high until `gnt1`.
- `a1`, input, BITS: operand of requester 1; must be valid while `req1` is high.
- `b_in`, input, 1: mode select, sampled with the operand. 0 = complement, 1 = increment.
- `gnt0`, output, 1: one-cycle pulse; operand `a0` is captured this cycle.
- `gnt1`, output, 1: one-cycle pulse; operand `a1` is captured this cycle.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse; `res`, `res_zero` and `res_id` are valid.
- `res`, output, BITS: lookup result; holds its value until the next `done`.
- `res_zero`, output, 1: high when `res` equals 0.
- `res_id`, output, 1: index of the requester that owns `res`.
- `op_cnt`, output, CNT_BITS: count of `done` pulses since reset; wraps modulo 2^CNT_BITS.

## Operation
- FSM states: IDLE, LOAD, EXEC, DONE. Encoding is 2-bit binary, in that order.
- IDLE:
  - If any request is high, latch the winner into `sel` and go to LOAD.
  - Otherwise stay in IDLE.
- Arbitration:
  - A lone request wins.
  - If both are high, the winner is the index not equal to `last`.
  - `last` is updated to the winner in LOAD.
  - `last` resets to 1, so `req0` wins the first tie.
- LOAD:
  - `gnt[sel]` is high.
  - Capture `op_r <= a[sel]` and `mode_r <= b_in`.
  - Go to EXEC.
- EXEC:
  - `lut_r <= mode_r ? op_r + 1 (mod 2^BITS) : ~op_r`.
  - Go to DONE.
- DONE:
  - Drive `done`=1, `res`=`lut_r`, `res_id`=`sel`.
  - Increment `op_cnt`.
  - Go to IDLE.
- Requests are sampled only in IDLE. A requester still holding `req` in the cycle after its `gnt` is treated as a new request at the next IDLE.
- Arithmetic: increment wraps (15+1 = 0 for BITS=4). Complement is bitwise, equivalent to `15 - a`.
- `op_cnt` wraps 255 -> 0; there is no saturation.

## Timing
- Reset values: `gnt0`=`gnt1`=`busy`=`done`=0, `res`=0, `res_zero`=1, `res_id`=0, `op_cnt`=0, state=IDLE, `last`=1.
- Reset while `busy`:
  - Abort immediately.
  - No `done` is issued and `op_cnt` is unchanged from its reset value.
  - The captured operand is discarded; the requester must re-request.
- Request seen high in IDLE at edge k:
  - `gnt` is high in cycle k+1 (LOAD).
  - `done` is high in cycle k+3 (DONE).
  - Back in IDLE at cycle k+4.
- Throughput: one operation per 4 cycles. A request sampled in the IDLE cycle of k+4 is granted at k+5.
- All outputs are either registers or decoded directly from state/`sel` registers. No input-to-output combinational paths.
- `res`, `res_zero` and `res_id` update only on entry to DONE. They are stable in every other cycle.

## Structure
- Shared defines file: `BITS`, the state encodings `ST_IDLE`/`ST_LOAD`/`ST_EXEC`/`ST_DONE`, and the mode constants `MODE_CPL`=0 and `MODE_INC`=1.
- One sub-module, `bm_lut_unit`:
  - Inputs: `clock`, `op`, `mode`, `en`.
  - Output: registered `lut`, loaded when `en` is high (EXEC).
  - Implements the complement/increment table.
- The arbiter, FSM and counter live in the top module.

## Test plan
- Reset:
  - Hold `reset_n`=0 for 2 cycles, then release.
  - All outputs equal their reset values; `busy`=0; `res_zero`=1.
- Single request:
  - `req0`=1, `a0`=4'b0011, `b_in`=0.
  - `gnt0` pulses 1 cycle after sampling.
  - `done` 3 cycles after sampling, with `res`=4'b1100, `res_id`=0, `op_cnt`=1.
- Tie, round-robin:
  - `req0`=`req1`=1 held continuously, with `a0`=5 and `a1`=9.
  - Grants alternate 0,1,0,1.
  - `res` sequence is 10, 6, 10, 6 (complement mode); `done` is spaced every 4 cycles.
- Increment wrap:
  - `req1`=1, `a1`=4'b1111, `b_in`=1.
  - `res`=0, `res_zero`=1, `res_id`=1.
- Reset mid-operation:
  - Assert `reset_n`=0 during EXEC.
  - No `done`; `op_cnt`=0; `busy`=0 the cycle after reset.
  - The following request completes normally with `res_id`=0 on a tie.
- Counter wrap:
  - Run 256 back-to-back operations.
  - `op_cnt` reads 0 after the 256th `done`.
